// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instruction memory
// while holding the CPU in reset. Optional macro: IMEM_BOOT_FILL_EN.
module imem_boot_loader #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_last,
  input  logic                  boot_req,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  err_overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

`ifdef IMEM_BOOT_FILL_EN
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd2,
    RUN  = 2'd3
  } state_t;
`endif

  localparam int LAST_INT = DEPTH - 1;
  localparam logic [ADDR_WIDTH:0] LAST_IDX =
    LAST_INT[ADDR_WIDTH:0];
  localparam logic [7:0] HOLD_W = HOLD_CYCLES[7:0];

`ifdef IMEM_BOOT_FILL_EN
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [ADDR_WIDTH-1:0] LAST_A =
    LAST_INT[ADDR_WIDTH-1:0];
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [ADDR_WIDTH-1:0] fill_n;
`endif

  state_t                state;
  state_t                state_n;
  logic [7:0]            hold_cnt;
  logic [7:0]            hold_n;
  logic                  wr_en_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           data_n;
  logic [ADDR_WIDTH:0]   wc_n;
  logic                  ovf_n;
  logic                  accept;

  assign in_ready  = (state == LOAD);
  assign accept    = in_valid && in_ready;
  assign cpu_reset = (state != RUN);
  assign done      = (state == RUN);

  // State register; any reset abandons the image and restarts at LOAD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_n;
    end
  end

  // Registered write port, load counters and hold timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      word_count   <= '0;
      err_overflow <= 1'b0;
      hold_cnt     <= '0;
`ifdef IMEM_BOOT_FILL_EN
      fill_addr    <= '0;
`endif
    end else begin
      wr_en        <= wr_en_n;
      wr_addr      <= addr_n;
      wr_data      <= data_n;
      word_count   <= wc_n;
      err_overflow <= ovf_n;
      hold_cnt     <= hold_n;
`ifdef IMEM_BOOT_FILL_EN
      fill_addr    <= fill_n;
`endif
    end
  end

  // Next-state and datapath decode.
  always_comb begin
    state_n = state;
    wr_en_n = 1'b0;
    addr_n  = wr_addr;
    data_n  = wr_data;
    wc_n    = word_count;
    ovf_n   = err_overflow;
    hold_n  = hold_cnt;
`ifdef IMEM_BOOT_FILL_EN
    fill_n  = fill_addr;
`endif
    case (state)
      LOAD: begin
        if (accept) begin
          wr_en_n = 1'b1;
          addr_n  = word_count[ADDR_WIDTH-1:0];
          data_n  = in_data;
          wc_n    = word_count + 1'b1;
          hold_n  = '0;
          if (in_last) begin
`ifdef IMEM_BOOT_FILL_EN
            if (word_count == LAST_IDX) begin
              state_n = HOLD;
            end else begin
              state_n = FILL;
              fill_n  = word_count[ADDR_WIDTH-1:0] + 1'b1;
            end
`else
            state_n = HOLD;
`endif
          end else if (word_count == LAST_IDX) begin
            ovf_n   = 1'b1;
            state_n = HOLD;
          end
        end
      end
`ifdef IMEM_BOOT_FILL_EN
      FILL: begin
        wr_en_n = 1'b1;
        addr_n  = fill_addr;
        data_n  = NOP;
        fill_n  = fill_addr + 1'b1;
        if (fill_addr == LAST_A) begin
          state_n = HOLD;
        end
      end
`endif
      HOLD: begin
        if (hold_cnt == HOLD_W) begin
          state_n = RUN;
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      RUN: begin
        if (boot_req) begin
          state_n = LOAD;
          wc_n    = '0;
          ovf_n   = 1'b0;
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed and randomized loads checked
// against a write-list model built from the words the bench sends.
module tb_imem_boot_loader;

  localparam int AW    = 8;
  localparam int DEPTH = 256;
  localparam int HOLD  = 4;
  localparam logic [31:0] NOP = 32'h00000013;
`ifdef IMEM_BOOT_FILL_EN
  localparam bit FILL = 1'b1;
`else
  localparam bit FILL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          boot_req = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_reset;
  logic          done;
  logic          err_overflow;
  logic [AW:0]   word_count;

  imem_boot_loader #(
    .ADDR_WIDTH(AW),
    .DEPTH(DEPTH),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .boot_req(boot_req),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_reset(cpu_reset),
    .done(done),
    .err_overflow(err_overflow),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          edg;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_acc = 0;
  int   rise_edge = -1;
  logic done_q = 1'b0;
  wr_t  wlog[$];
  wr_t  exp_q[$];

  // Memory-side observer: edge counter, write strobes, handshakes.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (wr_en === 1'b1)
      wlog.push_back('{int'(wr_addr), wr_data, cyc});
    if (in_valid && in_ready === 1'b1)
      n_acc = n_acc + 1;
  end

  // Records the edge at which done first rises.
  always @(negedge clk) begin
    if (done === 1'b1 && done_q !== 1'b1)
      rise_edge = cyc;
    done_q = done;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string p);
    chk({p, "_in_ready"}, in_ready, 1);
    chk({p, "_wr_en"}, wr_en, 0);
    chk({p, "_wr_addr"}, wr_addr, 0);
    chk({p, "_wr_data"}, wr_data, 0);
    chk({p, "_cpu_reset"}, cpu_reset, 1);
    chk({p, "_done"}, done, 0);
    chk({p, "_ovf"}, err_overflow, 0);
    chk({p, "_wc"}, word_count, 0);
  endtask

  task automatic start();
    wlog.delete();
    exp_q.delete();
    rise_edge = -1;
    n_acc = 0;
  endtask

  // gap: 0 back-to-back, 1 idle between words, 2 random idles.
  task automatic send(input logic [31:0] w[$],
                      input int last_idx,
                      input int gap);
    for (int i = 0; i < w.size(); i++) begin
      if ((gap == 1 && i > 0) ||
          (gap == 2 && $urandom_range(1, 0) == 1)) begin
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = (i == last_idx);
      if (i < DEPTH)
        exp_q.push_back('{i, w[i], cyc + 2});
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic add_fill(input int n);
    int e;
    e = exp_q[$].edg;
    if (FILL && n < DEPTH)
      for (int a = n; a < DEPTH; a++)
        exp_q.push_back('{a, NOP, e + 1 + a - n});
  endtask

  task automatic verify(input string p,
                        input int exp_n,
                        input bit exp_ovf);
    int mism;
    for (int i = 0; i < 3000 && rise_edge < 0; i++)
      @(negedge clk);
    chk({p, "_release_seen"}, rise_edge >= 0, 1);
    chk({p, "_word_count"}, word_count, exp_n);
    chk({p, "_accepts"}, n_acc, exp_n);
    chk({p, "_ovf"}, err_overflow, exp_ovf);
    chk({p, "_n_writes"}, wlog.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= wlog.size())
        mism++;
      else if (wlog[i].addr !== exp_q[i].addr ||
               wlog[i].data !== exp_q[i].data ||
               wlog[i].edg  !== exp_q[i].edg)
        mism++;
    end
    chk({p, "_write_list"}, mism, 0);
    chk({p, "_release_edge"}, rise_edge,
        exp_q[$].edg + HOLD);
    chk({p, "_cpu_reset"}, cpu_reset, 0);
    chk({p, "_done"}, done, 1);
    chk({p, "_in_ready"}, in_ready, 0);
  endtask

  task automatic reboot();
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    chk("rb_cpu_reset", cpu_reset, 1);
    chk("rb_done", done, 0);
    chk("rb_in_ready", in_ready, 1);
    chk("rb_wc", word_count, 0);
    chk("rb_ovf", err_overflow, 0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] q2[$];
    int len;

    repeat (2) @(negedge clk);
    check_reset("por");
    reset = 1'b1;

    q = '{32'h00500093, 32'h00A00113,
          32'h002081B3, 32'h00008067};
    start();
    send(q, 3, 0);
    add_fill(4);
    verify("four", 4, 0);

    reboot();
    start();
    send(q, 3, 1);
    add_fill(4);
    verify("gap", 4, 0);

    reboot();
    start();
    len = $urandom_range(20, 5);
    q.delete();
    for (int i = 0; i < len; i++)
      q.push_back($urandom);
    send(q, len - 1, 2);
    boot_req = 1'b1;
    @(negedge clk);
    boot_req = 1'b0;
    add_fill(len);
    verify("rand_hold_req", len, 0);

    reboot();
    start();
    q.delete();
    for (int i = 0; i < DEPTH; i++)
      q.push_back($urandom);
    send(q, -1, 0);
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (10) @(negedge clk);
    chk("ovf_extra_accept", n_acc, DEPTH);
    chk("ovf_in_ready", in_ready, 0);
    in_valid = 1'b0;
    verify("ovf", DEPTH, 1);

    reboot();
    start();
    q.delete();
    for (int i = 0; i < 6; i++)
      q.push_back($urandom);
    q2 = '{q[0], q[1], q[2]};
    send(q2, -1, 0);
    reset = 1'b0;
    #1;
    check_reset("mid");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    start();
    q2 = '{q[3], q[4]};
    send(q2, 1, 0);
    add_fill(2);
    verify("after_rst", 2, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Streams a program image into the pipelined CPU's instruction memory over a valid/ready word interface while holding the CPU in reset. Once the last word has been written, it releases the CPU to begin fetching from address 0. It sits directly upstream of the fetch stage's instruction memory and replaces hierarchical backdoor writes with a synthesizable load path.

## Interface
Parameters:
- ADDR_WIDTH, 8: word-address width of instruction memory.
- DEPTH, 256: number of instruction words; must equal 2**ADDR_WIDTH.
- HOLD_CYCLES, 4: cycles the CPU reset is held after the final write; range 1..255.

Ports:
- clk, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: source presents a word.
- in_ready, output, 1: loader accepts a word.
- in_data, input, 32: instruction word.
- in_last, input, 1: current word is the final word of the image.
- boot_req, input, 1: single-cycle pulse that restarts loading; only honoured in RUN.
- wr_en, output, 1: instruction memory write strobe.
- wr_addr, output, ADDR_WIDTH: instruction memory word address.
- wr_data, output, 32: instruction memory write data.
- cpu_reset, output, 1: active-high reset to the CPU core.
- done, output, 1: image loaded and CPU running.
- err_overflow, output, 1: image exceeded DEPTH words; sticky until the next load starts.
- word_count, output, ADDR_WIDTH+1: words accepted in the current or last load.

## Operation
- States are LOAD, FILL, HOLD and RUN. Reset enters LOAD.
- **LOAD**
  - in_ready = 1. This is the combinational decode (state == LOAD).
  - A word is accepted when in_valid && in_ready. Each accepted word is written to address word_count, then word_count increments.
  - Accepting a word with in_last = 1 moves to FILL, or to HOLD when fill is compiled out or word_count reaches DEPTH.
  - Accepting word index DEPTH-1 with in_last = 0 forces end of image. err_overflow is set, the state moves to HOLD, and later words are not accepted.
- **FILL**
  - Writes NOP 32'h00000013 to every address from word_count through DEPTH-1, one per cycle.
  - After writing DEPTH-1, moves to HOLD.
  - word_count does not change during FILL.
- **HOLD**
  - An internal counter counts HOLD_CYCLES cycles.
  - When the count expires, moves to RUN.
- **RUN**
  - cpu_reset = 0 and done = 1.
  - boot_req = 1 moves to LOAD and clears word_count, err_overflow and done. cpu_reset goes to 1 on the same edge.
- cpu_reset = 1 in every state except RUN.
- in_data is not interpreted. Any 32-bit value is written as given.
- boot_req outside RUN is ignored.

## Timing
- Reset values:
  - in_ready = 1, wr_en = 0, wr_addr = 0, wr_data = 0.
  - cpu_reset = 1, done = 0, err_overflow = 0, word_count = 0.
- Write latency is one cycle. A word accepted at edge N drives wr_en/wr_addr/wr_data during cycle N+1, and memory captures it at edge N+1. All three are registered.
- Throughput is one word per cycle. in_ready stays high through LOAD, so back-to-back transfers are supported.
- On the edge that accepts the last word, in_ready drops in the next cycle. No word is accepted in the cycle after last.
- FILL writes use the same registered path, so the first fill write immediately follows the last image write.
- After the final write strobe, cpu_reset stays high for exactly HOLD_CYCLES cycles. It falls at the same edge where done rises.
- Reset asserted mid-load or mid-fill:
  - Outputs go to their reset values immediately.
  - Any partial image is abandoned, and the next load starts at address 0.
- in_last together with overflow at word DEPTH-1: the word is treated as a legal last word and err_overflow stays 0.

## Configuration
- IMEM_BOOT_FILL_EN defined: FILL state is present and unused memory is NOP-padded.
- IMEM_BOOT_FILL_EN undefined:
  - FILL is removed and LOAD goes straight to HOLD.
  - Unused addresses keep their prior contents.
  - No write strobes occur beyond word_count-1.

## Test plan
- **Four-word load.** Reset low 2 cycles, then stream 00500093, 00A00113, 002081B3, 00008067 back-to-back with last on word 3.
  - Required: writes to addresses 0..3 at cycles 1..4 after acceptance, word_count = 4.
  - With FILL_EN: NOP at addresses 4..255.
  - Then cpu_reset falls HOLD_CYCLES cycles after the final write, and done = 1.
- **Gapped valid.** Drop in_valid on alternate cycles.
  - Required: same memory image, with no write strobe on idle cycles.
- **Overflow.** Send 256 words with no last.
  - Required: err_overflow = 1, word_count = 256, no fill writes, in_ready = 0 from then on.
  - Word 257 held valid stays unaccepted.
- **Reset mid-load.** Pull reset low after 3 of 6 words, then release and send 2 words.
  - Required: writes restart at address 0 and word_count = 2.
- **Reboot.** In RUN, pulse boot_req.
  - Required: cpu_reset = 1 and done = 0 next cycle, in_ready = 1, and a new image loads from address 0.
- **boot_req outside RUN.** Pulse boot_req during HOLD.
  - Required: no effect, and cpu_reset release timing is unchanged.
